// File: rtl/decode_rb_pipe_if.sv
// Toggle-handshake bundle around decode_rb_pipe: fetch side, execute side, register-bank read port.
// slave = the decode stage, master = the surrounding fetch/execute/register-bank environment.
interface decode_rb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [31:0]       dataIn;
  logic              readyIn;
  logic              triggerIn;
  logic [DATA_W-1:0] dataOut1;
  logic [DATA_W-1:0] dataOut2;
  logic [ADDR_W-1:0] destOut;
  logic [3:0]        typeOut;
  logic [3:0]        condOut;
  logic              setFlagsOut;
  logic              undefOut;
  logic              readyOut;
  logic              triggerOut;
  logic              ackIn;
  logic [ADDR_W-1:0] addrRB;
  logic              triggerOutRB;
  logic              triggerInRB;
  logic              readyInRB;
  logic [DATA_W-1:0] dataInRB;

  modport slave (
    input  dataIn, readyIn, triggerIn, ackIn, triggerInRB, readyInRB, dataInRB,
    output dataOut1, dataOut2, destOut, typeOut, condOut, setFlagsOut, undefOut,
           readyOut, triggerOut, addrRB, triggerOutRB
  );

  modport master (
    output dataIn, readyIn, triggerIn, ackIn, triggerInRB, readyInRB, dataInRB,
    input  dataOut1, dataOut2, destOut, typeOut, condOut, setFlagsOut, undefOut,
           readyOut, triggerOut, addrRB, triggerOutRB
  );
endinterface

// File: rtl/decode_rb_pipe.sv
// ARM data-processing decode stage: fetches Rn/Rm over a toggle handshake and issues to execute.
// Optional macro DECODE_SHIFT_EN enables the immediate-amount shift on register operand2.
module decode_rb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  decode_rb_pipe_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_RN, RD_RM, ISSUE, HOLD} state_e;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rn_val_q, rn_val_d, rm_val_q, rm_val_d;
  logic              trig_seen_q, trig_seen_d, ack_seen_q, ack_seen_d, rb_seen_q, rb_seen_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [ADDR_W-1:0] dest_q, dest_d, addr_rb_q, addr_rb_d;
  logic [3:0]        type_q, type_d, cond_q, cond_d;
  logic              setf_q, setf_d, undef_q, undef_d, ready_q, ready_d;
  logic              trig_out_q, trig_out_d, trig_rb_q, trig_rb_d;

  logic              trig_evt, ack_evt, rb_evt, instr_undef;
  logic [DATA_W-1:0] imm_exp, reg_opnd;

  function automatic logic is_undef(input logic [31:0] w);
    logic u;
    u = (w[27:26] != 2'b00);
`ifdef DECODE_SHIFT_EN
    // Shift-by-register forms are not supported by this stage.
    u = u | (!w[25] & w[4]);
`endif
    return u;
  endfunction

  function automatic logic needs_rn(input logic [31:0] w);
    return (w[24:21] != OP_MOV) && (w[24:21] != OP_MVN);
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned s);
    int unsigned k;
    k = s % DATA_W;
    return (k == 0) ? x : ((x >> k) | (x << (DATA_W - k)));
  endfunction

`ifdef DECODE_SHIFT_EN
  // Amount 0 follows the ARM encodings: LSR/ASR mean "by full width", ROR means RRX (carry-in 0).
  function automatic logic [DATA_W-1:0] shift_rm(input logic [DATA_W-1:0] x,
                                                 input logic [4:0] amt,
                                                 input logic [1:0] kind);
    logic [DATA_W-1:0]        r;
    logic signed [DATA_W-1:0] sx;
    unique case (kind)
      2'b00: r = x << amt;
      2'b01: r = (amt == 5'd0) ? '0 : (x >> amt);
      2'b10: begin
        if (amt == 5'd0) r = {DATA_W{x[DATA_W-1]}};
        else begin
          sx = $signed(x) >>> amt;
          r  = sx;
        end
      end
      default: r = (amt == 5'd0) ? (x >> 1) : rotr(x, 32'(amt));
    endcase
    return r;
  endfunction
`endif

  assign trig_evt    = (bus.triggerIn   != trig_seen_q);
  assign ack_evt     = (bus.ackIn       != ack_seen_q);
  assign rb_evt      = (bus.triggerInRB != rb_seen_q);
  assign instr_undef = is_undef(instr_q);
  assign imm_exp     = rotr(DATA_W'(instr_q[7:0]), {27'd0, instr_q[11:8], 1'b0});
`ifdef DECODE_SHIFT_EN
  assign reg_opnd    = shift_rm(rm_val_q, instr_q[11:7], instr_q[6:5]);
`else
  assign reg_opnd    = rm_val_q;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q so paths that do not assign it hold state, not a latch.
    state_d     = state_q;
    instr_d     = instr_q;
    rn_val_d    = rn_val_q;
    rm_val_d    = rm_val_q;
    trig_seen_d = trig_seen_q;
    ack_seen_d  = ack_seen_q;
    rb_seen_d   = rb_seen_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    dest_d      = dest_q;
    addr_rb_d   = addr_rb_q;
    type_d      = type_q;
    cond_d      = cond_q;
    setf_d      = setf_q;
    undef_d     = undef_q;
    ready_d     = ready_q;
    trig_out_d  = trig_out_q;
    trig_rb_d   = trig_rb_q;

    unique case (state_q)
      IDLE: if (trig_evt) begin
        trig_seen_d = bus.triggerIn;
        if (bus.readyIn) begin
          instr_d = bus.dataIn;
          if (is_undef(bus.dataIn)) begin
            state_d = ISSUE;
          end else if (needs_rn(bus.dataIn)) begin
            state_d   = RD_RN;
            addr_rb_d = ADDR_W'(bus.dataIn[19:16]);
            trig_rb_d = ~trig_rb_q;
          end else if (!bus.dataIn[25]) begin
            state_d   = RD_RM;
            addr_rb_d = ADDR_W'(bus.dataIn[3:0]);
            trig_rb_d = ~trig_rb_q;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      RD_RN: if (rb_evt) begin
        rb_seen_d = bus.triggerInRB;
        if (bus.readyInRB) begin
          rn_val_d = bus.dataInRB;
          if (!instr_q[25]) begin
            state_d   = RD_RM;
            addr_rb_d = ADDR_W'(instr_q[3:0]);
            trig_rb_d = ~trig_rb_q;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      RD_RM: if (rb_evt) begin
        rb_seen_d = bus.triggerInRB;
        if (bus.readyInRB) begin
          rm_val_d = bus.dataInRB;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        undef_d    = instr_undef;
        op1_d      = (!instr_undef && needs_rn(instr_q)) ? rn_val_q : '0;
        op2_d      = instr_undef ? '0 : (instr_q[25] ? imm_exp : reg_opnd);
        dest_d     = ADDR_W'(instr_q[15:12]);
        type_d     = instr_q[24:21];
        cond_d     = instr_q[31:28];
        setf_d     = instr_q[20];
        ready_d    = 1'b1;
        trig_out_d = ~trig_out_q;
        state_d    = HOLD;
      end
      HOLD: if (ack_evt) begin
        ack_seen_d = bus.ackIn;
        ready_d    = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each flop samples the pre-edge _d values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      rn_val_q    <= '0;
      rm_val_q    <= '0;
      trig_seen_q <= 1'b0;
      ack_seen_q  <= 1'b0;
      rb_seen_q   <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      dest_q      <= '0;
      addr_rb_q   <= '0;
      type_q      <= '0;
      cond_q      <= '0;
      setf_q      <= 1'b0;
      undef_q     <= 1'b0;
      ready_q     <= 1'b0;
      trig_out_q  <= 1'b0;
      trig_rb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rn_val_q    <= rn_val_d;
      rm_val_q    <= rm_val_d;
      trig_seen_q <= trig_seen_d;
      ack_seen_q  <= ack_seen_d;
      rb_seen_q   <= rb_seen_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      dest_q      <= dest_d;
      addr_rb_q   <= addr_rb_d;
      type_q      <= type_d;
      cond_q      <= cond_d;
      setf_q      <= setf_d;
      undef_q     <= undef_d;
      ready_q     <= ready_d;
      trig_out_q  <= trig_out_d;
      trig_rb_q   <= trig_rb_d;
    end
  end

  assign bus.dataOut1     = op1_q;
  assign bus.dataOut2     = op2_q;
  assign bus.destOut      = dest_q;
  assign bus.typeOut      = type_q;
  assign bus.condOut      = cond_q;
  assign bus.setFlagsOut  = setf_q;
  assign bus.undefOut     = undef_q;
  assign bus.readyOut     = ready_q;
  assign bus.triggerOut   = trig_out_q;
  assign bus.addrRB       = addr_rb_q;
  assign bus.triggerOutRB = trig_rb_q;

endmodule
